// File: rtl/vga_scanout_pkg.sv
// Shared raster geometry, palette and pipeline record for the VGA scanout path.
package vga_scanout_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int SCALE_SHIFT = 1;
  localparam int FB_W        = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_H        = V_ACTIVE >> SCALE_SHIFT;
  localparam int RD_LAT      = 2;
  localparam int PIX_W       = 2;
  localparam int ADDR_W      = 17;

  // Field order fixes the reset pattern of the alignment shift register.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic frame;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, frame: 1'b0};

  function automatic logic [11:0] palette_lookup(input logic [PIX_W-1:0] idx);
    case (idx)
      2'd0:    return 12'h000;
      2'd1:    return 12'hFFF;
      2'd2:    return 12'hF80;
      2'd3:    return 12'h08F;
      default: return 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/vga_scanout_delay_line.sv
// Fixed-depth shift register with asynchronous reset to a chosen value.
module vga_scanout_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // shift one stage per clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= RST_VAL;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// Scans the upscaled framebuffer out through the palette, keeping syncs aligned with colour.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int H_ACTIVE_P    = H_ACTIVE,
  parameter int V_ACTIVE_P    = V_ACTIVE,
  parameter int SCALE_SHIFT_P = SCALE_SHIFT,
  parameter int RD_LAT_P      = RD_LAT,
  parameter int ADDR_W_P      = ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                de_in,
  input  logic                frame_in,
  output logic [ADDR_W_P-1:0] fb_addr,
  output logic                fb_rd_en,
  input  logic [PIX_W-1:0]    fb_data,
  output logic                hsync,
  output logic                vsync,
  output logic [11:0]         rgb,
  output logic                frame_out
);

  localparam int PX_W = $clog2(H_ACTIVE_P);
  localparam int PY_W = $clog2(V_ACTIVE_P);
  // The pin register supplies the last stage of the total 1 + RD_LAT + 1 latency.
  localparam int SYNC_DEPTH = RD_LAT_P + 1;
  localparam logic [PX_W-1:0]     PX_MAX   = PX_W'(H_ACTIVE_P - 1);
  localparam logic [PY_W-1:0]     PY_MAX   = PY_W'(V_ACTIVE_P - 1);
  localparam logic [PY_W-1:0]     REP_MASK = PY_W'((1 << SCALE_SHIFT_P) - 1);
  localparam logic [ADDR_W_P-1:0] ROW_STEP = ADDR_W_P'(H_ACTIVE_P >> SCALE_SHIFT_P);

  logic [PX_W-1:0]     px_r;
  logic [PY_W-1:0]     py_r;
  logic [ADDR_W_P-1:0] row_base_r;
  logic                line_end_s;
  sync_t               sync_in_s;
  sync_t               sync_dly_s;

  // fb_rd_en doubles as the previous-cycle de_in for edge detection
  assign line_end_s = fb_rd_en & ~de_in;
  assign sync_in_s  = {hsync_in, vsync_in, de_in, frame_in};

  // raster position and start-of-row address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_r       <= '0;
      py_r       <= '0;
      row_base_r <= '0;
    end else if (frame_in) begin
      px_r       <= '0;
      py_r       <= '0;
      row_base_r <= '0;
    end else if (line_end_s) begin
      px_r <= '0;
      if (py_r != PY_MAX) begin
        py_r <= py_r + PY_W'(1);
      end
      if ((py_r & REP_MASK) == REP_MASK) begin
        row_base_r <= row_base_r + ROW_STEP;
      end
    end else if (de_in && (px_r != PX_MAX)) begin
      px_r <= px_r + PX_W'(1);
    end
  end

  // framebuffer read request; address holds outside active video
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_rd_en <= 1'b0;
      fb_addr  <= '0;
    end else begin
      fb_rd_en <= de_in;
      if (de_in) begin
        fb_addr <= row_base_r + ADDR_W_P'(px_r >> SCALE_SHIFT_P);
      end
    end
  end

  vga_scanout_delay_line #(
    .WIDTH   ($bits(sync_t)),
    .DEPTH   (SYNC_DEPTH),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk (clk),
    .rst (rst),
    .d   (sync_in_s),
    .q   (sync_dly_s)
  );

  // pin register: colour and syncs leave together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      frame_out <= 1'b0;
      rgb       <= 12'h000;
    end else begin
      hsync     <= sync_dly_s.hsync;
      vsync     <= sync_dly_s.vsync;
      frame_out <= sync_dly_s.frame;
      if (sync_dly_s.de) begin
        rgb <= palette_lookup(fb_data);
      end else begin
        rgb <= 12'h000;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: reset, addressing, row stepping, alignment, blanking.
module tb_vga_scanout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        de_in = 1'b0;
  logic        frame_in = 1'b0;
  logic [16:0] fb_addr;
  logic        fb_rd_en;
  logic [1:0]  fb_data = 2'd0;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic        frame_out;

  int checks = 0;
  int errors = 0;

  vga_scanout dut (
    .clk       (clk),
    .rst       (rst),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .de_in     (de_in),
    .frame_in  (frame_in),
    .fb_addr   (fb_addr),
    .fb_rd_en  (fb_rd_en),
    .fb_data   (fb_data),
    .hsync     (hsync),
    .vsync     (vsync),
    .rgb       (rgb),
    .frame_out (frame_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    de_in    = 1'b0;
    frame_in = 1'b1;
    tick();
    frame_in = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      hsync_in = k[0];
      vsync_in = k[1];
      de_in    = k[0];
      frame_in = k[1];
      fb_data  = k[1:0];
      tick();
      checks++;
      if ({hsync, vsync, rgb, fb_rd_en, fb_addr, frame_out} !== {1'b1, 1'b1, 12'h000, 1'b0, 17'd0, 1'b0}) begin
        errors++;
        $display("FAIL reset k=%0d: hs=%b vs=%b rgb=%h en=%b addr=%0d fo=%b, need 1 1 000 0 0 0",
                 k, hsync, vsync, rgb, fb_rd_en, fb_addr, frame_out);
      end
    end
    hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0; frame_in = 1'b0; fb_data = 2'd0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_line_addr();
    pulse_frame();
    de_in = 1'b1;
    for (int i = 0; i < 640; i++) begin
      tick();
      checks++;
      if (fb_rd_en !== 1'b1 || fb_addr !== 17'(i >> 1)) begin
        errors++;
        if (errors < 20)
          $display("FAIL line_addr px=%0d: en=%b addr=%0d, need en=1 addr=%0d", i, fb_rd_en, fb_addr, i >> 1);
      end
    end
    de_in = 1'b0;
    tick();
    checks++;
    if (fb_rd_en !== 1'b0 || fb_addr !== 17'd319) begin
      errors++;
      $display("FAIL line_hold: en=%b addr=%0d, need en=0 addr=319", fb_rd_en, fb_addr);
    end
  endtask

  task automatic test_rows();
    int exp_addr;
    pulse_frame();
    for (int line = 0; line < 480; line++) begin
      de_in = 1'b1;
      tick();
      exp_addr = (line / 2) * 320;
      if (line < 3 || line == 479) begin
        checks++;
        if (fb_addr !== 17'(exp_addr)) begin
          errors++;
          $display("FAIL row_start line=%0d: addr=%0d, need %0d", line, fb_addr, exp_addr);
        end
      end
      for (int k = 0; k < 3; k++) tick();
      de_in = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic test_sync_align();
    logic exp_b;
    for (int k = 0; k < 5; k++) tick();
    hsync_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_b = (k < 4);
      checks++;
      if (hsync !== exp_b) begin
        errors++;
        $display("FAIL hsync_delay k=%0d: hsync=%b, need %b", k, hsync, exp_b);
      end
    end
    hsync_in = 1'b1;
    vsync_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_b = (k < 4);
      checks++;
      if (vsync !== exp_b) begin
        errors++;
        $display("FAIL vsync_delay k=%0d: vsync=%b, need %b", k, vsync, exp_b);
      end
    end
    vsync_in = 1'b1;
    frame_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      frame_in = 1'b0;
      exp_b = (k == 4);
      checks++;
      if (frame_out !== exp_b) begin
        errors++;
        $display("FAIL frame_delay k=%0d: frame_out=%b, need %b", k, frame_out, exp_b);
      end
    end
    fb_data = 2'd1;
    de_in   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (rgb !== ((k >= 4) ? 12'hFFF : 12'h000)) begin
        errors++;
        $display("FAIL rgb_align k=%0d: rgb=%h, need %h", k, rgb, (k >= 4) ? 12'hFFF : 12'h000);
      end
    end
    fb_data = 2'd2;
    tick();
    checks++;
    if (rgb !== 12'hF80) begin
      errors++;
      $display("FAIL palette2: rgb=%h, need f80", rgb);
    end
    de_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (rgb !== ((k < 4) ? 12'hF80 : 12'h000)) begin
        errors++;
        $display("FAIL rgb_tail k=%0d: rgb=%h, need %h", k, rgb, (k < 4) ? 12'hF80 : 12'h000);
      end
    end
  endtask

  task automatic test_blank_saturate();
    fb_data = 2'd3;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (rgb !== 12'h000) begin
        errors++;
        $display("FAIL blank k=%0d: rgb=%h, need 000", k, rgb);
      end
    end
    pulse_frame();
    de_in = 1'b1;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (i == 639 || i == 699) begin
        checks++;
        if (fb_addr !== 17'd319) begin
          errors++;
          $display("FAIL saturate i=%0d: addr=%0d, need 319", i, fb_addr);
        end
      end
    end
    checks++;
    if (rgb !== 12'h08F) begin
      errors++;
      $display("FAIL palette3: rgb=%h, need 08f", rgb);
    end
    de_in = 1'b0;
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_reset_midline();
    fb_data = 2'd1;
    pulse_frame();
    for (int k = 0; k < 3; k++) begin
      de_in = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      de_in = 1'b0;
      tick();
      tick();
    end
    de_in    = 1'b1;
    hsync_in = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    checks++;
    if (fb_addr !== 17'd369 || rgb !== 12'hFFF || hsync !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset: addr=%0d rgb=%h hs=%b, need 369 fff 0", fb_addr, rgb, hsync);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({hsync, vsync, rgb, fb_rd_en, fb_addr, frame_out} !== {1'b1, 1'b1, 12'h000, 1'b0, 17'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: hs=%b vs=%b rgb=%h en=%b addr=%0d fo=%b, need 1 1 000 0 0 0",
               hsync, vsync, rgb, fb_rd_en, fb_addr, frame_out);
    end
    de_in    = 1'b0;
    hsync_in = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    hsync_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (hsync !== ((k < 4) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL post_reset_sync k=%0d: hsync=%b, need %b", k, hsync, (k < 4) ? 1'b1 : 1'b0);
      end
    end
    hsync_in = 1'b1;
    pulse_frame();
    de_in = 1'b1;
    tick();
    checks++;
    if (fb_rd_en !== 1'b1 || fb_addr !== 17'd0) begin
      errors++;
      $display("FAIL post_reset_addr: en=%b addr=%0d, need en=1 addr=0", fb_rd_en, fb_addr);
    end
    tick();
    tick();
    checks++;
    if (fb_addr !== 17'd1) begin
      errors++;
      $display("FAIL post_reset_addr2: addr=%0d, need 1", fb_addr);
    end
    de_in = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_line_addr();
    test_rows();
    test_sync_align();
    test_blank_saturate();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
